// File: rtl/bitwise_op_pipe_pkg.sv
// bitwise_op_pipe_pkg: op codes, FSM states and helpers shared by the bitwise op pipe
package bitwise_op_pipe_pkg;
  localparam logic [2:0] OP_AND     = 3'd0;
  localparam logic [2:0] OP_OR      = 3'd1;
  localparam logic [2:0] OP_XOR     = 3'd2;
  localparam logic [2:0] OP_NAND    = 3'd3;
  localparam logic [2:0] OP_NOR     = 3'd4;
  localparam logic [2:0] OP_XNOR    = 3'd5;
  localparam logic [2:0] OP_ACC_OR  = 3'd6;
  localparam logic [2:0] OP_ACC_AND = 3'd7;
  typedef enum logic {ST_IDLE = 1'b0, ST_ACCUM = 1'b1} state_t;
  function automatic logic is_acc(input logic [2:0] o);
    return o == OP_ACC_OR || o == OP_ACC_AND;
  endfunction
endpackage

// File: rtl/logic_node.sv
// logic_node: single-bit node; ops 6/7 return the OR/AND used by the accumulate fold
module logic_node
  import bitwise_op_pipe_pkg::*;
(
  input  logic       in,
  input  logic       inn,
  input  logic [2:0] sel,
  output logic       out
);
  always_comb begin
    case (sel)
      OP_AND, OP_ACC_AND: out = in & inn;
      OP_OR, OP_ACC_OR:   out = in | inn;
      OP_XOR:             out = in ^ inn;
      OP_NAND:            out = ~(in & inn);
      OP_NOR:             out = ~(in | inn);
      default:            out = ~(in ^ inn);
    endcase
  end
endmodule

// File: rtl/bitwise_op_pipe.sv
// bitwise_op_pipe: per-bit op array with accumulate FSM and a one-deep valid/ready output register
module bitwise_op_pipe
  import bitwise_op_pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [CNT_W-1:0] out_count
);
  state_t           r_state, w_state_nxt;
  logic [2:0]       r_op, w_sel;
  logic [WIDTH-1:0] r_acc, r_out, w_f, w_fold;
  logic [CNT_W-1:0] r_cnt, r_count, w_cnt_inc;
  logic             r_valid, w_fire, w_load, w_start;
  assign in_ready  = !r_valid || out_ready;
  assign w_fire    = in_valid && in_ready;
  assign w_sel     = r_state == ST_ACCUM ? r_op : op;
  assign out_valid = r_valid;
  assign out       = r_out;
  assign out_count = r_count;
  for (genvar i = 0; i < WIDTH; i++) begin : g_node
    logic_node u_node (.in(a[i]), .inn(b[i]), .sel(w_sel), .out(w_f[i]));
  end
  assign w_fold    = r_op == OP_ACC_OR ? r_acc | w_f : r_acc & w_f;
  assign w_cnt_inc = &r_cnt ? r_cnt : r_cnt + CNT_W'(1);
  // a first accumulate beat without in_last opens a sequence; every other accepted beat may emit
  always_comb begin
    w_start     = w_fire && r_state == ST_IDLE && is_acc(op) && !in_last;
    w_load      = w_fire && (r_state == ST_ACCUM ? in_last : !w_start);
    w_state_nxt = w_start ? ST_ACCUM : (w_load ? ST_IDLE : r_state);
  end
  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_IDLE;
    else r_state <= w_state_nxt;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_out   <= '0;
      r_count <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_op    <= OP_AND;
    end else begin
      if (w_load) r_valid <= 1'b1;
      else if (out_ready) r_valid <= 1'b0;
      if (w_load) begin
        r_out   <= r_state == ST_ACCUM ? w_fold : w_f;
        r_count <= r_state == ST_ACCUM ? w_cnt_inc : CNT_W'(1);
      end
      if (w_fire && !w_load) begin
        r_acc <= r_state == ST_ACCUM ? w_fold : w_f;
        r_cnt <= r_state == ST_ACCUM ? w_cnt_inc : CNT_W'(1);
      end
      if (w_start) r_op <= op;
    end
  end
endmodule

// File: tb/tb_bitwise_op_pipe.sv
// tb_bitwise_op_pipe: scoreboard bench driving a CNT_W=8 and a CNT_W=2 instance in lockstep
module tb_bitwise_op_pipe;
  logic       clk = 0, reset = 1, in_valid = 0, in_last = 0, out_ready = 0;
  logic [2:0] op = 0;
  logic [7:0] a = 0, b = 0;
  logic       rdy8, rdy2, ov8, ov2;
  logic [7:0] o8, o2, c8;
  logic [1:0] c2;
  typedef struct {logic [7:0] v; int n;} exp_t;
  exp_t       q[$];
  int         errors = 0, checks = 0;
  bit         in_seq = 0, pend = 0, p_last;
  logic [2:0] seq_op, p_op;
  logic [7:0] acc, p_a, p_b;
  int         n;

  always #5 clk = ~clk;

  bitwise_op_pipe #(.WIDTH(8), .CNT_W(8)) dut8 (
    .clock(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy8), .in_last(in_last),
    .op(op), .a(a), .b(b), .out_valid(ov8), .out_ready(out_ready), .out(o8), .out_count(c8));
  bitwise_op_pipe #(.WIDTH(8), .CNT_W(2)) dut2 (
    .clock(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy2), .in_last(in_last),
    .op(op), .a(a), .b(b), .out_valid(ov2), .out_ready(out_ready), .out(o2), .out_count(c2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] f(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    case (o)
      3'd0: return x & y;
      3'd1: return x | y;
      3'd2: return x ^ y;
      3'd3: return ~(x & y);
      3'd4: return ~(x | y);
      3'd5: return ~(x ^ y);
      3'd6: return x | y;
      default: return x & y;
    endcase
  endfunction

  function automatic void model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y, input bit l);
    if (!in_seq) begin
      if (o < 3'd6 || l) q.push_back('{f(o, x, y), 1});
      else begin
        in_seq = 1;
        seq_op = o;
        acc = f(o, x, y);
        n = 1;
      end
    end else begin
      acc = seq_op == 3'd6 ? (acc | x | y) : (acc & x & y);
      n++;
      if (l) begin
        q.push_back('{acc, n});
        in_seq = 0;
      end
    end
  endfunction

  task automatic step(input bit v, input bit l, input logic [2:0] o, input logic [7:0] x,
                      input logic [7:0] y, input bit ordy, input bit rst);
    @(posedge clk);
    if (reset) begin
      q.delete();
      in_seq = 0;
    end else if (pend) model(p_op, p_a, p_b, p_last);
    pend = 0;
    #1;
    in_valid = v; in_last = l; op = o; a = x; b = y; out_ready = ordy; reset = rst;
    @(negedge clk);
    pend = in_valid && rdy8 && !reset;
    p_op = op; p_a = a; p_b = b; p_last = in_last;
  endtask

  task automatic idle();
    step(0, 0, 3'd0, 8'h00, 8'h00, 1, 0);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      chk("in_ready", 32'(rdy8), 32'(q.size() == 0 || out_ready));
      chk("in_ready_c2", 32'(rdy2), 32'(q.size() == 0 || out_ready));
      chk("out_valid", 32'(ov8), 32'(q.size() != 0));
      chk("out_valid_c2", 32'(ov2), 32'(q.size() != 0));
      if (q.size() != 0) begin
        chk("out", 32'(o8), 32'(q[0].v));
        chk("out_c2", 32'(o2), 32'(q[0].v));
        chk("out_count", 32'(c8), 32'(q[0].n > 255 ? 255 : q[0].n));
        chk("out_count_c2", 32'(c2), 32'(q[0].n > 3 ? 3 : q[0].n));
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  initial begin
    logic [7:0] sx, sy, sor;
    repeat (3) step(0, 0, 3'd0, 8'h00, 8'h00, 0, 1);
    step(0, 0, 3'd0, 8'h00, 8'h00, 1, 0);
    chk("rst_out", 32'(o8), 32'h0);
    chk("rst_count", 32'(c8), 32'h0);
    chk("rst_ready", 32'(rdy8), 32'h1);
    step(1, 0, 3'd1, 8'hA0, 8'h05, 1, 0);
    idle();
    chk("or_a5", 32'(o8), 32'hA5);
    chk("or_a5_cnt", 32'(c8), 32'h1);
    for (int i = 0; i < 6; i++) step(1, 0, 3'(i), 8'hF0, 8'h3C, 1, 0);
    idle();
    step(1, 0, 3'd6, 8'h01, 8'h02, 1, 0);
    step(1, 0, 3'd3, 8'h04, 8'h00, 1, 0);
    chk("acc_no_early", 32'(ov8), 32'h0);
    step(1, 1, 3'd2, 8'h00, 8'h80, 1, 0);
    chk("acc_no_early2", 32'(ov8), 32'h0);
    idle();
    chk("acc_or", 32'(o8), 32'h87);
    chk("acc_or_cnt", 32'(c8), 32'h3);
    step(1, 0, 3'd1, 8'h11, 8'h22, 0, 0);
    repeat (3) step(1, 0, 3'd2, 8'h33, 8'h44, 0, 0);
    chk("hold_ready", 32'(rdy8), 32'h0);
    chk("hold_out", 32'(o8), 32'h33);
    step(1, 0, 3'd2, 8'h33, 8'h44, 1, 0);
    idle();
    chk("refill", 32'(o8), 32'h77);
    step(1, 0, 3'd7, 8'hF0, 8'hFF, 1, 0);
    step(1, 0, 3'd7, 8'h3C, 8'hFF, 1, 0);
    step(0, 0, 3'd0, 8'h00, 8'h00, 1, 1);
    step(0, 0, 3'd0, 8'h00, 8'h00, 1, 0);
    chk("midrst_valid", 32'(ov8), 32'h0);
    chk("midrst_out", 32'(o8), 32'h0);
    step(1, 1, 3'd7, 8'hFF, 8'h0F, 1, 0);
    idle();
    chk("and_single", 32'(o8), 32'h0F);
    chk("and_single_cnt", 32'(c8), 32'h1);
    sor = 0;
    for (int i = 0; i < 5; i++) begin
      sx = 8'(1 << i);
      sy = 8'(8'h80 >> i);
      sor |= sx | sy;
      step(1, i == 4, 3'd6, sx, sy, 1, 0);
    end
    idle();
    chk("sat_cnt2", 32'(c2), 32'h3);
    chk("sat_cnt8", 32'(c8), 32'h5);
    chk("sat_out", 32'(o2), 32'(sor));
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, 3'($urandom), 8'($urandom),
           8'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 299) == 0);
    repeat (4) idle();
    chk("drain", 32'(q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
